key_debounce_multi: RTL

//  Parametrised N-key debouncer/event generator for the clock's front-panel keys.
//  Per key it provides:
//  - a debounced level;
//  - one-cycle press and release pulses;
//  - a long-press pulse;
//  - an optional auto-repeat pulse train while the key is held.

---
 rtl/key_debounce_pkg.sv | 21 ++
 rtl/key_debounce_multi_if.sv | 22 ++
 rtl/key_debounce_chan.sv | 143 ++++++++++++++
 rtl/key_debounce_multi.sv | 43 ++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the multi-key debouncer: the per-key state
// encoding and the counter-width calculation.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED,
        KS_PRESS_CHK,
        KS_HELD,
        KS_RELEASE_CHK
    } key_state_t;

    // Sized to hold the largest of the three cycle thresholds.
    function automatic int cnt_width(input int deb, input int long_c, input int rep);
        int m;
        m = deb;
        if (long_c > m) m = long_c;
        if (rep > m) m = rep;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key-panel bundle: raw pins and repeat enable in, debounced level and event pulses out.
interface key_debounce_multi_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_in;
    logic                repeat_en;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;

    modport master (
        output key_in, repeat_en,
        input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  key_in, repeat_en,
        output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, and hold/repeat counters.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_pin,
    input  logic repeat_en,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = cnt_width(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    key_state_t state, state_nxt;
    logic sync1, sync2, raw_act;
    logic [CNT_W-1:0] deb_cnt, hold_cnt, rep_cnt;
    logic [CNT_W-1:0] deb_nxt, hold_nxt, rep_nxt;
    logic level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign raw_act = sync2 ^ INACTIVE;

    // Sync flops idle at the released pin level so a key held through reset looks like a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= INACTIVE;
            sync2         <= INACTIVE;
            state         <= KS_RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= key_pin;
            sync2         <= sync1;
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            key_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            KS_RELEASED:    if (raw_act) state_nxt = KS_PRESS_CHK;
            KS_PRESS_CHK:   if (!raw_act) state_nxt = KS_RELEASED;
                            else if (deb_cnt == DEB_C) state_nxt = KS_HELD;
            KS_HELD:        if (!raw_act) state_nxt = KS_RELEASE_CHK;
            KS_RELEASE_CHK: if (raw_act) state_nxt = KS_HELD;
                            else if (deb_cnt == DEB_C) state_nxt = KS_RELEASED;
            default:        state_nxt = KS_RELEASED;
        endcase
    end

    // Counter updates and next registered outputs; hold saturates so long fires once per press.
    always_comb begin
        deb_nxt     = deb_cnt;
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_cnt;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        unique case (state)
            KS_RELEASED: begin
                if (raw_act) deb_nxt = ONE_C;
            end
            KS_PRESS_CHK: begin
                if (!raw_act) begin
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_C) begin
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + ONE_C;
                end
            end
            KS_HELD: begin
                if (!raw_act) begin
                    deb_nxt = ONE_C;
                end else if (hold_cnt != LONG_C) begin
                    hold_nxt = hold_cnt + ONE_C;
                    if (hold_cnt + ONE_C == LONG_C) begin
                        long_nxt = 1'b1;
                        rep_nxt  = '0;
                    end
                end else if (repeat_en) begin
                    if (rep_cnt + ONE_C == REP_C) begin
                        repeat_nxt = 1'b1;
                        rep_nxt    = '0;
                    end else begin
                        rep_nxt = rep_cnt + ONE_C;
                    end
                end else begin
                    rep_nxt = '0;
                end
            end
            KS_RELEASE_CHK: begin
                if (!raw_act) begin
                    if (deb_cnt == DEB_C) begin
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                        deb_nxt     = '0;
                        hold_nxt    = '0;
                        rep_nxt     = '0;
                    end else begin
                        deb_nxt = deb_cnt + ONE_C;
                    end
                end
            end
            default: begin
                deb_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key channels sharing one auto-repeat enable.
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS      = 3,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    key_debounce_multi_if.slave kif
);

    logic [NUM_KEYS-1:0] level_v, press_v, release_v, long_v, repeat_v;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_pin      (kif.key_in[g]),
            .repeat_en    (kif.repeat_en),
            .key_level    (level_v[g]),
            .press_pulse  (press_v[g]),
            .release_pulse(release_v[g]),
            .long_pulse   (long_v[g]),
            .repeat_pulse (repeat_v[g])
        );
    end

    assign kif.key_level     = level_v;
    assign kif.press_pulse   = press_v;
    assign kif.release_pulse = release_v;
    assign kif.long_pulse    = long_v;
    assign kif.repeat_pulse  = repeat_v;

endmodule
